// File: rtl/uart_msg_sequencer_pkg.sv
// Purpose: shared token codes, ASCII constants and FSM encoding for the UART message sequencer.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package uart_msg_sequencer_pkg;

  // Template ROM token codes (one byte per ROM word)
  localparam logic [7:0] TOK_END  = 8'h00;  // end of message
  localparam logic [7:0] TOK_DIG  = 8'h10;  // 0x10+k : live BCD digit k
  localparam logic [7:0] TOK_COND = 8'h18;  // 0x18+f : next two words A,B chosen by flag f
  localparam logic [7:0] TOK_MASK = 8'hF8;  // low 3 bits carry k / f

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_Q = 8'h3F;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_START,
    ST_FETCH,
    ST_DECODE,
    ST_SEND,
    ST_WAIT,
    ST_END,
    ST_GAP
  } state_t;

  function automatic logic is_dig_tok(input logic [7:0] t);
    return (t & TOK_MASK) == TOK_DIG;
  endfunction

  function automatic logic is_cond_tok(input logic [7:0] t);
    return (t & TOK_MASK) == TOK_COND;
  endfunction

endpackage

// File: rtl/uart_msg_sequencer_if.sv
// Purpose: byte handshake between the message sequencer and the UART transmitter.
// Latency: n/a (wires only).
// Backpressure: transmitter holds off the next byte simply by delaying tx_done.
// Signals: send_en (1-cycle start pulse), data_byte (held until tx_done), tx_done (1-cycle byte-finished pulse).
interface uart_msg_sequencer_if;
  logic       send_en;
  logic [7:0] data_byte;
  logic       tx_done;

  modport master (output send_en, output data_byte, input tx_done);
  modport slave  (input send_en, input data_byte, output tx_done);
endinterface

// File: rtl/uart_msg_sequencer_msg_rom.sv
// Purpose: template byte ROM plus per-message base address table; message layout lives here only.
// Latency: o_dat is registered (1 cycle after i_addr); o_base is combinational from i_idx.
// Backpressure: none, read every cycle.
// Ports: clk; i_addr ROM word address; i_idx message index; o_dat ROM word; o_base start address of message i_idx.
module msg_rom #(
  parameter int ADDR_W = 9,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [IDX_W-1:0]  i_idx,
  output logic [7:0]        o_dat,
  output logic [ADDR_W-1:0] o_base
);

  logic [7:0] r_dat;

  // Msg 0 @0  : "CLS(0);\r\n"              one-shot screen clear
  // Msg 1 @16 : "T:" d1 d0 "\r\n"
  // Msg 2 @32 : "F" {f0?D2:CE} {f1?'1':'0'} {f7?'A':'B'} d2 "\r\n"
  // Msg 3 @48 : "ABC\n"
  // Msg 4 @64 : filler with no terminator, ends on the length guard
  // Msg 5 @192: "ALM" d3 "\r\n"             alarm text
  function automatic logic [7:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [7:0] w;
    int         ai;
    ai = int'(a);
    case (ai)
      0: w = 8'h43;  1: w = 8'h4C;  2: w = 8'h53;  3: w = 8'h28;  4: w = 8'h30;
      5: w = 8'h29;  6: w = 8'h3B;  7: w = 8'h0D;  8: w = 8'h0A;
      16: w = 8'h54; 17: w = 8'h3A; 18: w = 8'h11; 19: w = 8'h10; 20: w = 8'h0D; 21: w = 8'h0A;
      32: w = 8'h46; 33: w = 8'h18; 34: w = 8'hD2; 35: w = 8'hCE; 36: w = 8'h19; 37: w = 8'h31;
      38: w = 8'h30; 39: w = 8'h1F; 40: w = 8'h41; 41: w = 8'h42; 42: w = 8'h12; 43: w = 8'h0D;
      44: w = 8'h0A;
      48: w = 8'h41; 49: w = 8'h42; 50: w = 8'h43; 51: w = 8'h0A;
      192: w = 8'h41; 193: w = 8'h4C; 194: w = 8'h4D; 195: w = 8'h13; 196: w = 8'h0D; 197: w = 8'h0A;
      // 64..191: printable filler 0x40..0x5F, never a token or terminator
      default: w = (ai >= 64 && ai < 192) ? (8'h40 | {3'b000, a[4:0]}) : 8'h00;
    endcase
    return w;
  endfunction

  always_ff @(posedge clk) begin
    r_dat <= rom_word(i_addr);
  end

  assign o_dat = r_dat;

  always_comb begin
    o_base = '0;
    case (int'(i_idx))
      0:       o_base = ADDR_W'(0);
      1:       o_base = ADDR_W'(16);
      2:       o_base = ADDR_W'(32);
      3:       o_base = ADDR_W'(48);
      4:       o_base = ADDR_W'(64);
      5:       o_base = ADDR_W'(192);
      default: o_base = ADDR_W'(0);
    endcase
  end

endmodule

// File: rtl/uart_msg_sequencer.sv
// Purpose: streams templated messages from msg_rom to a UART tx, substituting live BCD digits and flag choices.
// Latency: first byte BOOT_CYC+3 clocks after reset; per byte FETCH/DECODE/SEND then WAIT for tx_done.
// Backpressure: one byte in flight; the next byte is fetched only after tx_done.
// Ports: clk, rst_n; digits (4*N_DIG BCD), flags (N_FLAG), alarm (level); tx (master side of byte
//        handshake); busy (message in progress); msg_idx (message being / last sent).
module uart_msg_sequencer
  import uart_msg_sequencer_pkg::*;
#(
  parameter int N_MSG      = 6,
  parameter int LOOP_START = 1,
  parameter int ALARM_MSG  = 5,
  parameter int N_DIG      = 8,
  parameter int N_FLAG     = 4,
  parameter int ADDR_W     = 9,
  parameter int BOOT_CYC   = 200_000,
  parameter int GAP_CYC    = 1_000,
  parameter int MAX_LEN    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*N_DIG-1:0]       digits,
  input  logic [N_FLAG-1:0]        flags,
  input  logic                     alarm,
  uart_msg_sequencer_if.master     tx,
  output logic                     busy,
  output logic [$clog2(N_MSG)-1:0] msg_idx
);

  localparam int IDX_W  = $clog2(N_MSG);
  localparam int BCNT_W = $clog2(MAX_LEN + 1);

  localparam logic [31:0]       BOOT_LAST = 32'(BOOT_CYC - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_MSG - 1);
  localparam logic [IDX_W-1:0]  LOOP_IDX  = IDX_W'(LOOP_START);
  localparam logic [IDX_W-1:0]  ALARM_IDX = IDX_W'(ALARM_MSG);
  localparam logic [BCNT_W-1:0] MAX_BC    = BCNT_W'(MAX_LEN);

  state_t              r_state;
  logic [31:0]         r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [1:0]          r_cond_ph;   // 0: normal token, 1: expecting A, 2: expecting B
  logic                r_cond_sel;
  logic [7:0]          r_cond_a;
  logic [7:0]          r_data;
  logic                r_send_en;
  logic                r_busy;
  logic [IDX_W-1:0]    r_msg_idx;
  logic [IDX_W-1:0]    r_seq_idx;   // position in the regular rotation; alarm service does not advance it
  logic [4*N_DIG-1:0]  r_dig_sh;
  logic [N_FLAG-1:0]   r_flag_sh;
  logic                r_alarm_s1, r_alarm_s2, r_alarm_d, r_alarm_latch;

  logic [7:0]          w_rom;
  logic [ADDR_W-1:0]   w_base;
  logic [7:0]          w_flag_ext;
  logic [7:0]          w_dig_ok;
  logic [3:0]          w_dig_arr [8];
  logic [2:0]          w_tok_lo;
  logic                w_alarm_edge;
  logic                w_serve;
  logic                w_take_alarm;
  logic [IDX_W-1:0]    w_seq_next;

  msg_rom #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_rom (
    .clk    (clk),
    .i_addr (r_addr),
    .i_idx  (r_msg_idx),
    .o_dat  (w_rom),
    .o_base (w_base)
  );

  // Token low bits can name digits/flags beyond what is wired; those read as absent.
  for (genvar g = 0; g < 8; g++) begin : g_ext
    if (g < N_FLAG) begin : g_flag
      assign w_flag_ext[g] = r_flag_sh[g];
    end else begin : g_noflag
      assign w_flag_ext[g] = 1'b0;
    end
    if (g < N_DIG) begin : g_dig
      assign w_dig_arr[g] = r_dig_sh[4*g +: 4];
      assign w_dig_ok[g]  = 1'b1;
    end else begin : g_nodig
      assign w_dig_arr[g] = 4'h0;
      assign w_dig_ok[g]  = 1'b0;
    end
  end

  assign w_tok_lo     = w_rom[2:0];
  assign w_alarm_edge = r_alarm_s2 & ~r_alarm_d;
  assign w_serve      = (r_state == ST_GAP) && (r_cnt == GAP_LAST);
  // An edge arriving on the very boundary cycle is served right away.
  assign w_take_alarm = r_alarm_latch | w_alarm_edge;
  assign w_seq_next   = (r_seq_idx == LAST_IDX) ? LOOP_IDX : r_seq_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm_s1    <= 1'b0;
      r_alarm_s2    <= 1'b0;
      r_alarm_d     <= 1'b0;
      r_alarm_latch <= 1'b0;
    end else begin
      r_alarm_s1 <= alarm;
      r_alarm_s2 <= r_alarm_s1;
      r_alarm_d  <= r_alarm_s2;
      if (w_serve && w_take_alarm) r_alarm_latch <= 1'b0;
      else if (w_alarm_edge)       r_alarm_latch <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BOOT;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_bcnt     <= '0;
      r_cond_ph  <= 2'd0;
      r_cond_sel <= 1'b0;
      r_cond_a   <= 8'h00;
      r_data     <= 8'h00;
      r_send_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_msg_idx  <= '0;
      r_seq_idx  <= '0;
      r_dig_sh   <= '0;
      r_flag_sh  <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_cnt == BOOT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_START: begin
          // Shadow copies keep one message self-consistent while inputs move.
          r_dig_sh  <= digits;
          r_flag_sh <= flags;
          r_addr    <= w_base;
          r_bcnt    <= '0;
          r_cond_ph <= 2'd0;
          r_busy    <= 1'b1;
          r_state   <= ST_FETCH;
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          case (r_cond_ph)
            2'd1: begin
              r_cond_a  <= w_rom;
              r_addr    <= r_addr + 1'b1;
              r_cond_ph <= 2'd2;
              r_state   <= ST_FETCH;
            end
            2'd2: begin
              // SEND's address increment then steps past B.
              r_data    <= r_cond_sel ? r_cond_a : w_rom;
              r_cond_ph <= 2'd0;
              r_send_en <= 1'b1;
              r_state   <= ST_SEND;
            end
            default: begin
              if (w_rom == TOK_END || r_bcnt == MAX_BC) begin
                r_busy  <= 1'b0;
                r_state <= ST_END;
              end else if (is_cond_tok(w_rom)) begin
                r_cond_sel <= w_flag_ext[w_tok_lo];
                r_addr     <= r_addr + 1'b1;
                r_cond_ph  <= 2'd1;
                r_state    <= ST_FETCH;
              end else begin
                if (is_dig_tok(w_rom))
                  r_data <= w_dig_ok[w_tok_lo] ? {ASCII_0[7:4], w_dig_arr[w_tok_lo]} : ASCII_Q;
                else
                  r_data <= w_rom;
                r_send_en <= 1'b1;
                r_state   <= ST_SEND;
              end
            end
          endcase
        end
        ST_SEND: begin
          r_send_en <= 1'b0;
          r_bcnt    <= r_bcnt + 1'b1;
          r_addr    <= r_addr + 1'b1;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: if (tx.tx_done) r_state <= ST_FETCH;
        ST_END: begin
          r_cnt   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (w_serve) begin
            r_cnt   <= '0;
            r_state <= ST_START;
            if (w_take_alarm) begin
              r_msg_idx <= ALARM_IDX;
            end else begin
              r_msg_idx <= w_seq_next;
              r_seq_idx <= w_seq_next;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign tx.send_en   = r_send_en;
  assign tx.data_byte = r_data;
  assign busy         = r_busy;
  assign msg_idx      = r_msg_idx;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Purpose: randomized self-checking bench for uart_msg_sequencer against a message-level reference model.
// Latency: n/a.
// Backpressure: UART model answers each send_en with tx_done 10 clocks later.
module tb_uart_msg_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] digits;
  logic [3:0]  flags;
  logic        alarm;
  logic        busy;
  logic [2:0]  msg_idx;

  uart_msg_sequencer_if u_if ();

  uart_msg_sequencer #(
    .N_MSG(6), .LOOP_START(1), .ALARM_MSG(5), .N_DIG(8), .N_FLAG(4),
    .ADDR_W(9), .BOOT_CYC(16), .GAP_CYC(20), .MAX_LEN(64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .digits  (digits),
    .flags   (flags),
    .alarm   (alarm),
    .tx      (u_if.master),
    .busy    (busy),
    .msg_idx (msg_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int          cyc;
  bit          inmsg;
  bit          first_pend;
  int          exp_idx;
  int          seq_pos;
  int          done_cnt = 0;
  int          n_msg0 = 0;
  int          alarm_req = 0;   // requests made by stimulus
  int          alarm_seen = 0;  // requests the model has already scheduled
  int          rst_epoch = 0;
  bit          rand_en = 0;
  logic [31:0] snap_dig;
  logic [3:0]  snap_flg;
  logic [7:0]  cur_q [$];
  logic [7:0]  exp_q [$];

  function automatic logic [7:0] dg(input logic [31:0] d, input int k);
    return 8'h30 | {4'h0, d[4*k +: 4]};
  endfunction

  // Expected wire bytes of message idx given the inputs in force when it started.
  task automatic build_exp(input int idx, input logic [31:0] d, input logic [3:0] f);
    exp_q.delete();
    case (idx)
      0: exp_q = '{8'h43, 8'h4C, 8'h53, 8'h28, 8'h30, 8'h29, 8'h3B, 8'h0D, 8'h0A};
      1: exp_q = '{8'h54, 8'h3A, dg(d, 1), dg(d, 0), 8'h0D, 8'h0A};
      2: exp_q = '{8'h46, (f[0] ? 8'hD2 : 8'hCE), (f[1] ? 8'h31 : 8'h30), 8'h42, dg(d, 2), 8'h0D, 8'h0A};
      3: exp_q = '{8'h41, 8'h42, 8'h43, 8'h0A};
      4: for (int i = 0; i < 64; i++) exp_q.push_back(8'h40 | 8'(i % 32));
      default: exp_q = '{8'h41, 8'h4C, 8'h4D, dg(d, 3), 8'h0D, 8'h0A};
    endcase
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; inmsg = 0; first_pend = 1; exp_idx = 0; seq_pos = 0;
      cur_q.delete();
    end else begin
      cyc++;
      if (!busy && !inmsg) begin
        snap_dig = digits;
        snap_flg = flags;
      end
      if (busy && !inmsg) begin
        inmsg = 1;
        chk("msg_idx", 32'(msg_idx), 32'(exp_idx));
        if (msg_idx == 3'd0) n_msg0++;
      end
      if (u_if.send_en) begin
        if (first_pend) begin
          chk($sformatf("first_send_cyc%0d", cyc), 32'(cyc >= 17 && cyc <= 24), 32'd1);
          first_pend = 0;
        end
        cur_q.push_back(u_if.data_byte);
      end
      if (!busy && inmsg) begin
        inmsg = 0;
        build_exp(exp_idx, snap_dig, snap_flg);
        chk($sformatf("m%0d_len", exp_idx), 32'(cur_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cur_q.size(); i++)
          chk($sformatf("m%0d_b%0d", exp_idx, i), 32'(cur_q[i]), 32'(exp_q[i]));
        cur_q.delete();
        done_cnt++;
        if (alarm_req != alarm_seen) begin
          alarm_seen = alarm_req;
          exp_idx = 5;
        end else begin
          seq_pos = (seq_pos == 5) ? 1 : seq_pos + 1;
          exp_idx = seq_pos;
        end
      end
    end
  end

  // ---------------- UART tx model ----------------
  initial begin
    logic [7:0] b;
    int         ep;
    u_if.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.send_en) begin
        b  = u_if.data_byte;
        ep = rst_epoch;
        repeat (10) @(negedge clk);
        if (ep == rst_epoch) chk("byte_hold", 32'(u_if.data_byte), 32'(b));
        u_if.tx_done = 1'b1;
        @(negedge clk);
        u_if.tx_done = 1'b0;
      end else if (rst_n && !busy && $urandom_range(0, 40) == 0) begin
        // Stray completion outside a transfer must be ignored.
        u_if.tx_done = 1'b1;
        @(negedge clk);
        u_if.tx_done = 1'b0;
      end
    end
  end

  // Inputs move only mid-message, so the model's idle-time snapshot is what START captured.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_en && busy && $urandom_range(0, 5) == 0) begin
        digits = $urandom;
        flags  = 4'($urandom_range(0, 15));
      end
    end
  end

  // ---------------- sequencing ----------------
  task automatic wait_busy_idx(input int idx, input int budget);
    int c = 0;
    while (!(busy && int'(msg_idx) == idx) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (!(busy && int'(msg_idx) == idx)) chk($sformatf("timeout_busy_m%0d", idx), 32'd0, 32'd1);
  endtask

  task automatic wait_msgs(input int n, input int budget);
    int c = 0;
    while (done_cnt < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_cnt < n) chk("timeout_msgs", 32'(done_cnt), 32'(n));
  endtask

  initial begin
    int base;
    int c;
    rst_n  = 1'b0;
    digits = 32'h0000_2573;
    flags  = 4'b0001;
    alarm  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_send_en", 32'(u_if.send_en), 32'd0);
    chk("rst_data", 32'(u_if.data_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_msg_idx", 32'(msg_idx), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // msg 1 first pass uses digits 2573 -> "T:73"; afterwards inputs churn mid-message.
    wait_busy_idx(1, 2000);
    rand_en = 1;

    // Two alarm pulses while msg 2 is being sent collapse into one service of msg 5.
    wait_busy_idx(2, 2000);
    repeat (4) @(negedge clk);
    alarm_req++;
    alarm = 1'b1; repeat (3) @(negedge clk);
    alarm = 1'b0; repeat (3) @(negedge clk);
    alarm = 1'b1; repeat (3) @(negedge clk);
    alarm = 1'b0;

    // 0,1,2,5,3,4,5,1,2,3,4,5,1
    wait_msgs(13, 20000);
    chk("msg0_once", 32'(n_msg0), 32'd1);

    // Reset while a byte is outstanding.
    c = 0;
    while (!u_if.send_en && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (!u_if.send_en) chk("timeout_send", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_epoch++;
    rst_n = 1'b0;
    #1;
    chk("midrst_send_en", 32'(u_if.send_en), 32'd0);
    chk("midrst_data", 32'(u_if.data_byte), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_msg_idx", 32'(msg_idx), 32'd0);
    repeat (2) @(negedge clk);
    base = done_cnt;
    #2 rst_n = 1'b1;
    wait_msgs(base + 2, 4000);
    chk("msg0_after_rst", 32'(n_msg0), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
